// File: rtl/muldiv_seq_if.sv
// Operand/result bus between the EX-stage pipeline and the HI/LO multiply/divide sequencer.
interface muldiv_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative shift-add multiply / restoring divide sequencer owning the MIPS HI/LO registers.
// Defining MULDIV_SIGNED_EN makes op[2] select signed MULT/DIV.
module muldiv_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic        i_clk,
    input  logic        i_reset,
    muldiv_seq_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFin} state_e;

    state_e               r_state;
    logic [CntW-1:0]      r_cnt;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_quo;
    logic [WIDTH-1:0]     r_dvsr;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_dbz;
    logic                 r_neg_res;
    logic                 r_neg_rem;

    logic                 w_sgn;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic                 w_last;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH:0]       w_div_sh;
    logic [WIDTH:0]       w_div_diff;
    logic                 w_div_ok;
    logic [WIDTH-1:0]     w_rem_nxt;
    logic [WIDTH-1:0]     w_quo_nxt;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_rem_res;
    logic [WIDTH-1:0]     w_quo_res;

`ifdef MULDIV_SIGNED_EN
    assign w_sgn = bus.op[2];
`else
    logic w_unused_op2;
    assign w_unused_op2 = bus.op[2];
    assign w_sgn        = 1'b0;
`endif

    // Datapath always works on magnitudes; signs are reapplied on the final iteration.
    assign w_a_neg = w_sgn & bus.a[WIDTH-1];
    assign w_b_neg = w_sgn & bus.b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -bus.a : bus.a;
    assign w_b_mag = w_b_neg ? -bus.b : bus.b;

    assign w_last = (r_cnt == CntW'(WIDTH - 1));

    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                       (r_mplier[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_acc_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Top bit of the difference is the borrow of the trial subtraction.
    assign w_div_sh   = {r_rem, r_quo[WIDTH-1]};
    assign w_div_diff = w_div_sh - {1'b0, r_dvsr};
    assign w_div_ok   = ~w_div_diff[WIDTH];
    assign w_rem_nxt  = w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
    assign w_quo_nxt  = {r_quo[WIDTH-2:0], w_div_ok};

    assign w_prod    = r_neg_res ? -w_acc_nxt : w_acc_nxt;
    assign w_quo_res = r_neg_res ? -w_quo_nxt : w_quo_nxt;
    assign w_rem_res = r_neg_rem ? -w_rem_nxt : w_rem_nxt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvsr    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        unique case (bus.op[1:0])
                            2'b00: begin
                                r_mcand   <= w_a_mag;
                                r_mplier  <= w_b_mag;
                                r_acc     <= '0;
                                r_cnt     <= '0;
                                r_neg_res <= w_a_neg ^ w_b_neg;
                                r_neg_rem <= w_a_neg;
                                r_busy    <= 1'b1;
                                r_state   <= StMul;
                            end
                            2'b01: begin
                                r_quo     <= w_a_mag;
                                r_dvsr    <= w_b_mag;
                                r_rem     <= '0;
                                r_cnt     <= '0;
                                r_neg_res <= w_a_neg ^ w_b_neg;
                                r_neg_rem <= w_a_neg;
                                r_busy    <= 1'b1;
                                r_state   <= StDiv;
                            end
                            2'b10:   r_hi <= bus.a;
                            default: r_lo <= bus.a;
                        endcase
                    end
                end
                StMul: begin
                    r_acc    <= w_acc_nxt;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CntW'(1);
                    if (w_last) begin
                        r_hi    <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo    <= w_prod[WIDTH-1:0];
                        r_done  <= 1'b1;
                        r_state <= StFin;
                    end
                end
                StDiv: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + CntW'(1);
                    if (w_last) begin
                        r_hi    <= w_rem_res;
                        r_lo    <= w_quo_res;
                        r_done  <= 1'b1;
                        r_dbz   <= (r_dvsr == '0);
                        r_state <= StFin;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_dbz   <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;
endmodule
